// File: rtl/candy_pkg.sv
// Shared definitions for the candy machine: state encoding and coin values.
package candy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int unsigned NICKEL  = 5;
  localparam int unsigned DIME    = 10;
  localparam int unsigned QUARTER = 25;

  // Value in cents of the coins pulsed this cycle; simultaneous coins add up.
  function automatic int unsigned coin_sum(input logic five, input logic ten,
                                           input logic twentyfive);
    int unsigned s;
    s = 0;
    if (five)       s += NICKEL;
    if (ten)        s += DIME;
    if (twentyfive) s += QUARTER;
    return s;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts cycles spent waiting for an actuator ack; flags the cycle in which the
// count would reach ACK_TIMEOUT.
module ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Terminal count depends only on en, so the FSM can use it without a loop through clr.
  always_comb begin
    tc = en && (cnt_q == CntW'(ACK_TIMEOUT - 1));
  end

endmodule

// File: rtl/candy_vend_ctrl.sv
// Candy dispenser sequencer: coin credit accumulation, vend handshake, nickel-by-nickel
// change/refund and an actuator-stall fault.
module candy_vend_ctrl #(
  parameter int unsigned PRICE       = 25,
  parameter int unsigned MAX_CREDIT  = 95,
  parameter int unsigned CREDIT_W    = 7,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                five,
  input  logic                ten,
  input  logic                twentyfive,
  input  logic                cancel,
  input  logic                candy_ack,
  input  logic                change_ack,
  output logic                candy_req,
  output logic                change_req,
  output logic                coin_reject,
  output logic                fault,
  output logic [CREDIT_W-1:0] credit
);

  import candy_pkg::*;

  localparam logic [CREDIT_W:0]   MaxC    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PriceC  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NickelC = CREDIT_W'(NICKEL);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_d;
  logic                candy_req_q, change_req_q, fault_q, coin_reject_q;

  logic [CREDIT_W:0]   coin_s;
  logic [CREDIT_W:0]   credit_sum;
  logic                any_coin;
  logic                ack_ok;
  logic                timer_en, timer_clr, timer_tc;

  // Coin adder with one spare bit so the ceiling check cannot wrap.
  always_comb begin
    any_coin   = five | ten | twentyfive;
    coin_s     = (CREDIT_W + 1)'(coin_sum(five, ten, twentyfive));
    credit_sum = {1'b0, credit_q} + coin_s;
  end

  // Handshake bookkeeping: only acks matching the current request count.
  always_comb begin
    ack_ok    = ((state_q == VEND) && candy_ack) || ((state_q == CHANGE) && change_ack);
    timer_en  = ((state_q == VEND) || (state_q == CHANGE)) && !ack_ok;
    timer_clr = ack_ok || (state_d != state_q);
  end

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr),
    .en (timer_en),
    .tc (timer_tc)
  );

  // Next state, next credit and coin rejection.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = any_coin;
    case (state_q)
      IDLE: begin
        if (cancel && (credit_q != '0)) begin
          // Refund wins over vend; coins this cycle stay rejected.
          state_d = CHANGE;
        end else begin
          if (any_coin && (credit_sum <= MaxC)) begin
            credit_d      = credit_sum[CREDIT_W-1:0];
            coin_reject_d = 1'b0;
          end
          // Vend decision uses registered credit, giving one cycle of coin-to-vend latency.
          if (credit_q >= PriceC) begin
            state_d = VEND;
          end
        end
      end
      VEND: begin
        if (candy_ack) begin
          credit_d = credit_q - PriceC;
          state_d  = (credit_q == PriceC) ? IDLE : CHANGE;
        end else if (timer_tc) begin
          state_d = FAULT;
        end
      end
      CHANGE: begin
        if (change_ack) begin
          if (credit_q <= NickelC) begin
            credit_d = '0;
            state_d  = IDLE;
          end else begin
            credit_d = credit_q - NickelC;
          end
        end else if (timer_tc) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (cancel) begin
          state_d = CHANGE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, credit and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      candy_req_q   <= 1'b0;
      change_req_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      candy_req_q   <= (state_d == VEND);
      change_req_q  <= (state_d == CHANGE);
      fault_q       <= (state_d == FAULT);
    end
  end

  assign candy_req   = candy_req_q;
  assign change_req  = change_req_q;
  assign fault       = fault_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_candy_vend_ctrl.sv
// Directed bench for candy_vend_ctrl with a scoreboard queue of expected outputs.
module tb_candy_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       five, ten, twentyfive, cancel, candy_ack, change_ack;
  logic       candy_req, change_req, coin_reject, fault;
  logic [6:0] credit;

  // Second instance with a raised price for the ceiling scenario.
  logic       c_quarter, c_ack;
  logic       c_candy_req, c_change_req, c_coin_reject, c_fault;
  logic [6:0] c_credit;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string      tag;
    logic [6:0] credit;
    logic       cr;
    logic       chr;
    logic       rej;
    logic       flt;
  } exp_t;

  exp_t sb[$];
  exp_t csb[$];

  always #5 clk = ~clk;

  candy_vend_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .five       (five),
    .ten        (ten),
    .twentyfive (twentyfive),
    .cancel     (cancel),
    .candy_ack  (candy_ack),
    .change_ack (change_ack),
    .candy_req  (candy_req),
    .change_req (change_req),
    .coin_reject(coin_reject),
    .fault      (fault),
    .credit     (credit)
  );

  candy_vend_ctrl #(
    .PRICE     (100),
    .MAX_CREDIT(100)
  ) dut_ceil (
    .clk        (clk),
    .rst        (rst),
    .five       (1'b0),
    .ten        (1'b0),
    .twentyfive (c_quarter),
    .cancel     (1'b0),
    .candy_ack  (c_ack),
    .change_ack (1'b0),
    .candy_req  (c_candy_req),
    .change_req (c_change_req),
    .coin_reject(c_coin_reject),
    .fault      (c_fault),
    .credit     (c_credit)
  );

  task automatic cmp(input string tag, input string field, input logic [7:0] got,
                     input logic [7:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      $display("FAIL %s.%s observed=%0d expected=%0d", tag, field, got, want);
      $error("check %s.%s observed %0d expected %0d", tag, field, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [6:0] c, input logic cr, input logic chr,
                      input logic rej, input logic flt);
    exp_t e;
    e.tag = tag; e.credit = c; e.cr = cr; e.chr = chr; e.rej = rej; e.flt = flt;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the main DUT outputs now.
  task automatic check_main();
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    n_pass++;
    e = sb.pop_front();
    cmp(e.tag, "credit", {1'b0, credit}, {1'b0, e.credit});
    cmp(e.tag, "candy_req", {7'd0, candy_req}, {7'd0, e.cr});
    cmp(e.tag, "change_req", {7'd0, change_req}, {7'd0, e.chr});
    cmp(e.tag, "coin_reject", {7'd0, coin_reject}, {7'd0, e.rej});
    cmp(e.tag, "fault", {7'd0, fault}, {7'd0, e.flt});
  endtask

  task automatic clear_inputs();
    five = 0; ten = 0; twentyfive = 0; cancel = 0; candy_ack = 0; change_ack = 0;
    c_quarter = 0; c_ack = 0;
  endtask

  // Inputs already driven; record the expectation for after the next edge, then check it.
  task automatic step(input string tag, input logic [6:0] c, input logic cr, input logic chr,
                      input logic rej, input logic flt);
    push(tag, c, cr, chr, rej, flt);
    @(posedge clk);
    #1;
    check_main();
    clear_inputs();
  endtask

  task automatic cstep(input string tag, input logic [6:0] c, input logic cr, input logic rej);
    exp_t e;
    e.tag = tag; e.credit = c; e.cr = cr; e.chr = 1'b0; e.rej = rej; e.flt = 1'b0;
    csb.push_back(e);
    @(posedge clk);
    #1;
    e = csb.pop_front();
    cmp(e.tag, "ceil_credit", {1'b0, c_credit}, {1'b0, e.credit});
    cmp(e.tag, "ceil_candy_req", {7'd0, c_candy_req}, {7'd0, e.cr});
    cmp(e.tag, "ceil_coin_reject", {7'd0, c_coin_reject}, {7'd0, e.rej});
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    push("reset", 7'd0, 0, 0, 0, 0);
    check_main();
    #6;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cancel with no credit is ignored.
    cancel = 1; step("cancel_zero", 7'd0, 0, 0, 0, 0);

    // Exact price.
    twentyfive = 1; step("t1_coin", 7'd25, 0, 0, 0, 0);
    step("t1_vend", 7'd25, 1, 0, 0, 0);
    candy_ack = 1; step("t1_ack", 7'd0, 0, 0, 0, 0);
    step("t1_idle", 7'd0, 0, 0, 0, 0);

    // Change return after simultaneous coins.
    five = 1; ten = 1; twentyfive = 1; step("t2_coins", 7'd40, 0, 0, 0, 0);
    step("t2_vend", 7'd40, 1, 0, 0, 0);
    candy_ack = 1; step("t2_ack", 7'd15, 0, 1, 0, 0);
    change_ack = 1; step("t2_n1", 7'd10, 0, 1, 0, 0);
    change_ack = 1; step("t2_n2", 7'd5, 0, 1, 0, 0);
    change_ack = 1; step("t2_n3", 7'd0, 0, 0, 0, 0);

    // Refund and reject during CHANGE.
    ten = 1; step("t3_ten1", 7'd10, 0, 0, 0, 0);
    ten = 1; step("t3_ten2", 7'd20, 0, 0, 0, 0);
    step("t3_hold", 7'd20, 0, 0, 0, 0);
    cancel = 1; step("t3_cancel", 7'd20, 0, 1, 0, 0);
    twentyfive = 1; step("t3_reject", 7'd20, 0, 1, 1, 0);
    change_ack = 1; step("t3_n1", 7'd15, 0, 1, 0, 0);
    change_ack = 1; step("t3_n2", 7'd10, 0, 1, 0, 0);
    change_ack = 1; step("t3_n3", 7'd5, 0, 1, 0, 0);
    change_ack = 1; step("t3_n4", 7'd0, 0, 0, 0, 0);

    // Ceiling on the PRICE=100 / MAX_CREDIT=100 instance.
    c_quarter = 1; cstep("t4_q1", 7'd25, 0, 0);
    c_quarter = 1; cstep("t4_q2", 7'd50, 0, 0);
    c_quarter = 1; cstep("t4_q3", 7'd75, 0, 0);
    c_quarter = 1; cstep("t4_q4", 7'd100, 0, 0);
    c_quarter = 1; cstep("t4_q5", 7'd100, 1, 1);
    c_ack = 1; cstep("t4_ack", 7'd0, 0, 0);

    // Timeout: ack withheld for ACK_TIMEOUT cycles of VEND.
    twentyfive = 1; step("t5_coin", 7'd25, 0, 0, 0, 0);
    step("t5_vend", 7'd25, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step("t5_wait", 7'd25, 1, 0, 0, 0);
    end
    step("t5_fault", 7'd25, 0, 0, 0, 1);
    candy_ack = 1; step("t5_ack_ignored", 7'd25, 0, 0, 0, 1);
    cancel = 1; step("t5_cancel", 7'd25, 0, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      change_ack = 1; step("t5_refund", 7'(i * 5), 0, 1, 0, 0);
    end
    change_ack = 1; step("t5_done", 7'd0, 0, 0, 0, 0);

    // Async reset in the middle of CHANGE, between clock edges.
    twentyfive = 1; ten = 1; step("t6_coins", 7'd35, 0, 0, 0, 0);
    step("t6_vend", 7'd35, 1, 0, 0, 0);
    candy_ack = 1; step("t6_change", 7'd10, 0, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    push("t6_reset", 7'd0, 0, 0, 0, 0);
    check_main();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
